core_seq_ctrl: RTL and testbench

- Job-level sequencer that generates the 35-bit instruction word driving the core (activation/weight SRAM, PE array, output FIFO, psum SRAM).
- On a start pulse it runs one tile in weight-stationary (WS) or output-stationary (OS) mode:
  - fetches weights and activations from activation SRAM into L0;
  - loads and executes the array;
  - drains the output FIFO into psum SRAM (OS) or the SFP accumulator (WS).
- Sits between the host/testbench job interface and the core's inst port.

---
 rtl/core_seq_ctrl.sv | 253 +++++++++++++++++++++++++
 tb/tb_core_seq_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : core_seq_ctrl
// Purpose  : Job-level sequencer producing the 35-bit core instruction word.
//            On an accepted start it runs one tile in weight-stationary (WS)
//            or output-stationary (OS) mode: weight fetch, array load,
//            activation execute, pipeline flush, and output-FIFO drain into
//            psum SRAM (OS) or the SFP accumulator (WS).
// Ports    : clk, reset (async, active-low)
//            start, mode, w_base, a_base, p_base, n_act  - job request
//            ofifo_valid                                  - output FIFO status
//            inst[34:0], busy, done                       - registered outputs
//            perf_cycles[31:0]      - only with CORE_SEQ_CTRL_PERF_EN defined
// Options  : `define CORE_SEQ_CTRL_PERF_EN adds a saturating per-job cycle
//            counter (start edge through the DONE edge).
// Revision : 1.0 - initial release
// ============================================================================
module core_seq_ctrl #(
    parameter int ROW    = 8,
    parameter int COL    = 8,
    parameter int ADDR_W = 11,
    parameter int CNT_W  = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic [CNT_W-1:0]  n_act,
    input  logic              ofifo_valid,
    output logic [34:0]       inst,
    output logic              busy,
    output logic              done
`ifdef CORE_SEQ_CTRL_PERF_EN
    ,
    output logic [31:0]       perf_cycles
`endif
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_LOADW = 3'd1;
    localparam logic [2:0] c_LOAD  = 3'd2;
    localparam logic [2:0] c_EXEC  = 3'd3;
    localparam logic [2:0] c_FLUSH = 3'd4;
    localparam logic [2:0] c_DRAIN = 3'd5;
    localparam logic [2:0] c_DONE  = 3'd6;

    localparam logic [34:0]      c_IDLE_WORD = 35'h1_800C_0000;
    localparam logic [CNT_W-1:0] c_ROW_LAST  = CNT_W'(ROW - 1);
    localparam logic [CNT_W-1:0] c_LOAD_LAST = CNT_W'(ROW + COL - 1);

    logic [2:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_rdCnt;   // ofifo reads issued, including the current cycle
    logic [CNT_W-1:0]  r_wrCnt;   // psum/acc writes issued, including the current cycle
    logic [CNT_W-1:0]  r_nAct;
    logic [ADDR_W-1:0] r_wBase;
    logic [ADDR_W-1:0] r_aBase;
    logic [ADDR_W-1:0] r_pBase;
    logic              r_mode;
    logic              r_xRd;     // shadow of the current cycle's xmem read strobe
    logic              r_ordCur;  // current cycle pops the output FIFO
    logic [34:0]       r_inst;
    logic              r_busy;
    logic              r_done;

    logic              w_accept;
    logic [2:0]        w_nextState;
    logic [CNT_W-1:0]  w_nextCnt;
    logic              w_nextRd;
    logic              w_nextWr;
    logic              w_nextMode;
    logic [ADDR_W-1:0] w_wBaseSel;
    logic [ADDR_W-1:0] w_aBaseSel;
    logic [34:0]       w_inst;

    assign w_accept   = (r_state == c_IDLE) && start;
    assign w_nextMode = w_accept ? mode : r_mode;
    // On the accepting edge the first LOADW/EXEC address comes straight from the inputs.
    assign w_wBaseSel = w_accept ? w_base : r_wBase;
    assign w_aBaseSel = w_accept ? a_base : r_aBase;

    // Next-state logic: the instruction word for the upcoming cycle is built
    // from the upcoming state so that every output is a plain register.
    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextRd    = 1'b0;
        w_nextWr    = 1'b0;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_nextCnt = '0;
                    if (!mode)             w_nextState = c_LOADW;
                    else if (n_act == '0)  w_nextState = c_FLUSH;
                    else                   w_nextState = c_EXEC;
                end
            end
            c_LOADW: begin
                if (r_cnt == c_ROW_LAST) begin
                    w_nextState = c_LOAD;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_LOAD: begin
                if (r_cnt == c_LOAD_LAST) begin
                    w_nextState = (r_nAct == '0) ? c_FLUSH : c_EXEC;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_EXEC: begin
                if (r_cnt == r_nAct - 1'b1) begin
                    w_nextState = c_FLUSH;
                    w_nextCnt   = '0;
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_FLUSH: begin
                if (r_cnt == c_LOAD_LAST) begin
                    w_nextCnt = '0;
                    if (r_nAct == '0) begin
                        w_nextState = c_DONE;
                    end else begin
                        w_nextState = c_DRAIN;
                        w_nextRd    = ofifo_valid && (r_rdCnt < r_nAct);
                    end
                end else begin
                    w_nextCnt = r_cnt + 1'b1;
                end
            end
            c_DRAIN: begin
                if (r_wrCnt == r_nAct) begin
                    w_nextState = c_DONE;
                end else begin
                    // A pop this cycle is always written next cycle, stall or not.
                    w_nextWr = r_ordCur;
                    w_nextRd = ofifo_valid && (r_rdCnt < r_nAct);
                end
            end
            c_DONE:  w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    // Instruction word for the upcoming cycle.
    always_comb begin
        w_inst     = c_IDLE_WORD;
        w_inst[34] = w_nextMode;
        w_inst[2]  = r_xRd;  // l0_wr trails the SRAM read by one cycle in every state
        case (w_nextState)
            c_LOADW: begin
                w_inst[19]   = 1'b0;
                w_inst[17:7] = w_wBaseSel + w_nextCnt[ADDR_W-1:0];
            end
            c_LOAD: begin
                w_inst[3] = 1'b1;
                w_inst[0] = 1'b1;
            end
            c_EXEC: begin
                w_inst[19]   = 1'b0;
                w_inst[17:7] = w_aBaseSel + w_nextCnt[ADDR_W-1:0];
                w_inst[3]    = 1'b1;
                w_inst[1]    = 1'b1;
            end
            c_FLUSH: begin
                w_inst[3] = 1'b1;
                w_inst[1] = 1'b1;
            end
            c_DRAIN: begin
                w_inst[4] = w_nextRd;
                if (w_nextWr) begin
                    w_inst[30:20] = r_pBase + r_wrCnt[ADDR_W-1:0];
                    if (r_mode) begin
                        w_inst[32] = 1'b0;
                        w_inst[31] = 1'b0;
                    end else begin
                        w_inst[6] = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_rdCnt  <= '0;
            r_wrCnt  <= '0;
            r_nAct   <= '0;
            r_wBase  <= '0;
            r_aBase  <= '0;
            r_pBase  <= '0;
            r_mode   <= 1'b0;
            r_xRd    <= 1'b0;
            r_ordCur <= 1'b0;
            r_inst   <= c_IDLE_WORD;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_cnt    <= w_nextCnt;
            r_inst   <= w_inst;
            r_xRd    <= ~w_inst[19];
            r_ordCur <= w_nextRd;
            r_busy   <= (w_nextState != c_IDLE) && (w_nextState != c_DONE);
            r_done   <= (w_nextState == c_DONE);
            if (w_accept) begin
                r_mode  <= mode;
                r_wBase <= w_base;
                r_aBase <= a_base;
                r_pBase <= p_base;
                r_nAct  <= n_act;
                r_rdCnt <= '0;
                r_wrCnt <= '0;
            end else begin
                if (w_nextRd) r_rdCnt <= r_rdCnt + 1'b1;
                if (w_nextWr) r_wrCnt <= r_wrCnt + 1'b1;
            end
        end
    end

    assign inst = r_inst;
    assign busy = r_busy;
    assign done = r_done;

`ifdef CORE_SEQ_CTRL_PERF_EN
    logic [31:0] r_perf;

    // Every edge that leaves a non-IDLE state is counted, DONE included.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_perf <= '0;
        end else if (w_accept) begin
            r_perf <= '0;
        end else if ((r_state != c_IDLE) && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule
`default_nettype wire

// File: tb/tb_core_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_seq_ctrl
// Purpose  : Directed self-checking bench for core_seq_ctrl: reset, WS job,
//            OS job, address wrap with drain stall, n_act=0, start while busy.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_seq_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [10:0] w_base = '0;
    logic [10:0] a_base = '0;
    logic [10:0] p_base = '0;
    logic [11:0] n_act = '0;
    logic        ofifo_valid = 1'b1;
    logic [34:0] inst;
    logic        busy;
    logic        done;
`ifdef CORE_SEQ_CTRL_PERF_EN
    logic [31:0] perf_cycles;
`endif

    int nChecks = 0;
    int nErrors = 0;

    int xa[$];
    int pw[$];
    int ac[$];
    int nLoad, nFlush, nBusy, nDone, nL0Wr, nOrd;
    int l0Bad, modeBad, stallBad, fixBad;

    core_seq_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .n_act       (n_act),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .busy        (busy),
        .done        (done)
`ifdef CORE_SEQ_CTRL_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        nChecks++;
        if (obs !== expv) begin
            nErrors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic checkList(input string tag, input int got[$], input int expv[$]);
        check({tag, "_len"}, got.size(), expv.size());
        for (int i = 0; i < expv.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", tag, i), got[i], expv[i]);
    endtask

    // Runs one job and records what the instruction stream did, cycle by cycle.
    task automatic runJob(input logic m, input logic [10:0] wb, input logic [10:0] ab,
                          input logic [10:0] pb, input logic [11:0] n,
                          input int stallAfterRd, input int busyPulseAt);
        int  cyc;
        int  stallLeft;
        bit  stalled;
        bit  finished;
        bit  prevXRd;
        bit  prevValid;
        xa.delete(); pw.delete(); ac.delete();
        nLoad = 0; nFlush = 0; nBusy = 0; nDone = 0; nL0Wr = 0; nOrd = 0;
        l0Bad = 0; modeBad = 0; stallBad = 0; fixBad = 0;
        @(negedge clk);
        mode = m; w_base = wb; a_base = ab; p_base = pb; n_act = n;
        ofifo_valid = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0; stallLeft = 0; stalled = 0; finished = 0;
        prevXRd = 0; prevValid = 1;
        while (!finished && cyc < 3000) begin
            if (busy) nBusy++;
            if (done) begin nDone++; finished = 1; end
            if (!inst[19]) begin
                xa.push_back(int'(inst[17:7]));
                if (!inst[18]) fixBad++;
            end
            if (inst[2] !== prevXRd) l0Bad++;
            if (inst[2]) nL0Wr++;
            if (inst[0]) nLoad++;
            if (inst[1] && inst[19]) nFlush++;
            if (!inst[32]) begin
                pw.push_back(int'(inst[30:20]));
                if (inst[31]) fixBad++;
            end
            if (inst[6]) ac.push_back(int'(inst[30:20]));
            if (inst[4]) begin
                nOrd++;
                if (!prevValid) stallBad++;
            end
            if (inst[34] !== m) modeBad++;
            if (inst[33] || inst[5]) fixBad++;
            prevXRd = !inst[19];
            if (stallAfterRd > 0 && nOrd == stallAfterRd && !stalled) begin
                stallLeft = 5;
                stalled = 1;
            end
            ofifo_valid = (stallLeft == 0);
            if (stallLeft > 0) stallLeft--;
            prevValid = ofifo_valid;
            start = (cyc == busyPulseAt);
            mode  = (cyc == busyPulseAt) ? ~m : m;
            cyc++;
            if (!finished) @(negedge clk);
        end
        start = 1'b0;
        mode  = m;
        ofifo_valid = 1'b1;
        if (!finished) check("job_timeout", 0, 1);
    endtask

    task automatic checkIdleAfter(input string tag, input logic m);
        @(negedge clk);
        check({tag, "_idle_inst"}, inst, {m, 34'h1_800C_0000});
        check({tag, "_idle_busy"}, busy, 0);
        check({tag, "_idle_done"}, done, 0);
    endtask

    initial begin
        // Power-on reset
        #12;
        check("rst_inst", inst, 35'h1_800C_0000);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        @(negedge clk);
        reset = 1'b1;

        // Reset in the middle of an EXEC phase
        @(negedge clk);
        mode = 1'b1; a_base = 11'd0; p_base = 11'd0; n_act = 12'd16; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("pre_rst_exec", inst[1], 1);
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b0;
        #1;
        check("midrst_inst", inst, 35'h1_800C_0000);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        @(negedge clk);
        check("midrst_hold_done", done, 0);
        reset = 1'b1;

        runJob(1'b1, 11'd0, 11'd5, 11'd7, 12'd2, 0, -1);
        checkList("postrst_rd", xa, '{5, 6});
        checkList("postrst_wr", pw, '{7, 8});
        check("postrst_busy", nBusy, 21);
        check("postrst_done", nDone, 1);

        // WS job
        runJob(1'b0, 11'd0, 11'd8, 11'd0, 12'd4, 0, -1);
        checkList("ws_rd", xa, '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11});
        checkList("ws_acc", ac, '{0, 1, 2, 3});
        check("ws_load", nLoad, 16);
        check("ws_flush", nFlush, 16);
        check("ws_psum_wr", pw.size(), 0);
        check("ws_l0wr_cnt", nL0Wr, 12);
        check("ws_l0wr_align", l0Bad, 0);
        check("ws_busy", nBusy, 49);
        check("ws_done", nDone, 1);
        check("ws_ord", nOrd, 4);
        check("ws_fixed", fixBad, 0);
        check("ws_mode", modeBad, 0);
`ifdef CORE_SEQ_CTRL_PERF_EN
        @(negedge clk);
        check("ws_perf", perf_cycles, 50);
`endif
        checkIdleAfter("ws", 1'b0);

        // OS job
        runJob(1'b1, 11'd0, 11'd100, 11'd200, 12'd3, 0, -1);
        checkList("os_rd", xa, '{100, 101, 102});
        checkList("os_wr", pw, '{200, 201, 202});
        check("os_load", nLoad, 0);
        check("os_acc", ac.size(), 0);
        check("os_flush", nFlush, 16);
        check("os_mode", modeBad, 0);
        check("os_busy", nBusy, 23);
        check("os_l0wr_align", l0Bad, 0);
        check("os_fixed", fixBad, 0);
        checkIdleAfter("os", 1'b1);

        // Address wrap with a 5-cycle ofifo_valid drop during DRAIN
        runJob(1'b1, 11'd0, 11'd2046, 11'd50, 12'd4, 2, -1);
        checkList("wrap_rd", xa, '{2046, 2047, 0, 1});
        checkList("wrap_wr", pw, '{50, 51, 52, 53});
        check("stall_no_ord", stallBad, 0);
        check("stall_ord", nOrd, 4);
        check("stall_done", nDone, 1);
        check("stall_busy_gt", nBusy > 27, 1);

        // n_act = 0 in WS, with a start pulse (and flipped mode) while busy
        runJob(1'b0, 11'd16, 11'd0, 11'd0, 12'd0, 0, 10);
        checkList("zero_rd", xa, '{16, 17, 18, 19, 20, 21, 22, 23});
        check("zero_load", nLoad, 16);
        check("zero_flush", nFlush, 16);
        check("zero_psum", pw.size(), 0);
        check("zero_acc", ac.size(), 0);
        check("zero_ord", nOrd, 0);
        check("zero_busy", nBusy, 40);
        check("zero_done", nDone, 1);
        check("zero_mode", modeBad, 0);
        checkIdleAfter("zero", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
`default_nettype wire
